// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Round-robin arbiter that shares one registered output stream (FIFO write
//   side / logger) among N_SRC stream sources. One source is granted at a time
//   for a burst of at most MAX_BURST beats, then arbitration rotates.
//
// Ports
//   aclk       clock, all logic on the rising edge
//   areset     synchronous active-high reset
//   s_valid    per-source data valid
//   s_data     per-source data, source i at [i*DATA_W +: DATA_W]
//   s_ready    per-source accept, at most one bit high
//   m_valid    output beat valid
//   m_data     output beat data
//   m_ready    downstream accept
//   grant_idx  index of the current or last grantee
//   busy       high while a burst is in progress
//   m_src      (ARB_TAG_EN only) source index of the beat on m_data
//
// Configuration macro: ARB_TAG_EN adds the m_src output and its register.

module fifo_drain_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int IDX_W     = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [N_SRC-1:0]        s_valid,
  input  logic [N_SRC*DATA_W-1:0] s_data,
  output logic [N_SRC-1:0]        s_ready,
  output logic                    m_valid,
  output logic [DATA_W-1:0]       m_data,
  input  logic                    m_ready,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy
`ifdef ARB_TAG_EN
  ,
  output logic [IDX_W-1:0]        m_src
`endif
);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [IDX_W-1:0]   r_grantIdx;
  logic [IDX_W-1:0]   w_grantNext;
  logic [IDX_W-1:0]   w_rrPick;
  logic [7:0]         r_beatCnt;
  logic [7:0]         w_beatCntNext;
  logic               r_mValid;
  logic [DATA_W-1:0]  r_mData;
  logic               w_loadEn;
  logic               w_grantValid;
  logic               w_accept;
  logic [DATA_W-1:0]  w_grantData;
`ifdef ARB_TAG_EN
  logic [IDX_W-1:0]   r_mSrc;
`endif

  // The output register can take a new beat when it is empty or being drained.
  assign w_loadEn     = !r_mValid || m_ready;
  assign w_grantValid = s_valid[r_grantIdx];
  assign w_accept     = (r_state == ST_BURST) && w_loadEn && w_grantValid;
  assign w_grantData  = s_data[int'(r_grantIdx)*DATA_W +: DATA_W];

  // Round-robin search: first requester strictly after the last grantee,
  // wrapping modulo N_SRC, so the last grantee is considered last.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    w_rrPick = r_grantIdx;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = IDX_W'((int'(r_grantIdx) + k) % N_SRC);
      if (!found && s_valid[cand]) begin
        w_rrPick = cand;
        found    = 1'b1;
      end
    end
  end

  // Next-state logic: IDLE spends one cycle picking a grantee; BURST ends when
  // the grantee stops requesting or the beat budget is used up.
  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grantIdx;
    w_beatCntNext = r_beatCnt;
    unique case (r_state)
      ST_IDLE: begin
        if (|s_valid) begin
          w_stateNext   = ST_BURST;
          w_grantNext   = w_rrPick;
          w_beatCntNext = '0;
        end
      end
      ST_BURST: begin
        if (!w_grantValid) begin
          w_stateNext = ST_IDLE;
        end else if (w_accept) begin
          w_beatCntNext = r_beatCnt + 8'd1;
          if (r_beatCnt == 8'(MAX_BURST - 1)) begin
            w_stateNext = ST_IDLE;
          end
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Only the grantee sees ready, and only when the output register can load.
  always_comb begin
    s_ready = '0;
    if ((r_state == ST_BURST) && w_loadEn) begin
      s_ready[r_grantIdx] = 1'b1;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= ST_IDLE;
      r_grantIdx <= IDX_W'(N_SRC - 1);
      r_beatCnt  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_grantIdx <= w_grantNext;
      r_beatCnt  <= w_beatCntNext;
    end
  end

  // One-entry output register; data is held while the downstream stalls.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_mValid <= 1'b0;
      r_mData  <= '0;
    end else if (w_loadEn) begin
      r_mValid <= w_accept;
      if (w_accept) begin
        r_mData <= w_grantData;
      end
    end
  end

`ifdef ARB_TAG_EN
  // Source tag travels alongside the data beat it describes.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_mSrc <= '0;
    end else if (w_accept) begin
      r_mSrc <= r_grantIdx;
    end
  end

  assign m_src = r_mSrc;
`endif

  assign m_valid   = r_mValid;
  assign m_data    = r_mData;
  assign grant_idx = r_grantIdx;
  assign busy      = (r_state == ST_BURST);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Testbench for fifo_drain_arbiter (N_SRC=4, DATA_W=32, MAX_BURST=8).
// Directed scenarios followed by a randomized phase; every cycle the DUT is
// compared with a burst-level reference model of the arbitration rules.

module tb_fifo_drain_arbiter;

  localparam int N_SRC     = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int IDX_W     = 2;

  logic                    aclk;
  logic                    areset;
  logic [N_SRC-1:0]        s_valid;
  logic [N_SRC*DATA_W-1:0] s_data;
  logic [N_SRC-1:0]        s_ready;
  logic                    m_valid;
  logic [DATA_W-1:0]       m_data;
  logic                    m_ready;
  logic [IDX_W-1:0]        grant_idx;
  logic                    busy;
`ifdef ARB_TAG_EN
  logic [IDX_W-1:0]        m_src;
`endif

  fifo_drain_arbiter #(
    .N_SRC(N_SRC), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .IDX_W(IDX_W)
  ) dut (
    .aclk(aclk), .areset(areset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .grant_idx(grant_idx), .busy(busy)
`ifdef ARB_TAG_EN
    , .m_src(m_src)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int passCount = 0;
  int totalCount = 0;

  // Reference model: which source owns the stream, how many beats it has
  // already delivered in this burst, and what the output register holds.
  bit          modelKnown = 0;
  bit          mBurst;
  int          mGrant;
  int          mTaken;
  bit          mOutValid;
  logic [31:0] mOutData;
  int          mOutSrc;
  int          seqNo [N_SRC];
  int          srcBeats [16];

  function automatic logic [31:0] srcWord(int i, int s);
    logic [7:0] low;
    low = 8'(8'hA0 + s);
    return {4'(i), 20'h0, low};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [31:0] expReady;
    expReady = '0;
    if (mBurst && (!mOutValid || m_ready)) expReady[mGrant] = 1'b1;
    checkOutput("s_ready", 32'(s_ready), expReady);
    checkOutput("m_valid", 32'(m_valid), 32'(mOutValid));
    checkOutput("m_data", m_data, mOutData);
    checkOutput("grant_idx", 32'(grant_idx), 32'(mGrant));
    checkOutput("busy", 32'(busy), 32'(mBurst));
`ifdef ARB_TAG_EN
    checkOutput("m_src", 32'(m_src), 32'(mOutSrc));
`endif
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic modelStep(input logic [N_SRC-1:0] sv, input bit mr, input bit rst);
    bit canLoad;
    bit took;
    if (rst) begin
      modelKnown = 1;
      mBurst     = 0;
      mGrant     = N_SRC - 1;
      mTaken     = 0;
      mOutValid  = 0;
      mOutData   = '0;
      mOutSrc    = 0;
      return;
    end
    canLoad = !mOutValid || mr;
    took    = mBurst && canLoad && sv[mGrant];
    if (canLoad) mOutValid = took;
    if (took) begin
      mOutData = srcWord(mGrant, seqNo[mGrant]);
      mOutSrc  = mGrant;
      seqNo[mGrant]++;
    end
    if (!mBurst) begin
      if (sv != '0) begin
        for (int k = 1; k <= N_SRC; k++) begin
          if (sv[(mGrant + k) % N_SRC]) begin
            mGrant = (mGrant + k) % N_SRC;
            break;
          end
        end
        mBurst = 1;
        mTaken = 0;
      end
    end else if (!sv[mGrant]) begin
      mBurst = 0;
    end else if (took) begin
      mTaken++;
      if (mTaken == MAX_BURST) mBurst = 0;
    end
  endtask

  // One full clock cycle: drive inputs, compare against the model, count
  // delivered beats per source, then let the model and the DUT advance.
  task automatic applyStimulus(input logic [N_SRC-1:0] sv, input bit mr, input bit rst);
    @(negedge aclk);
    areset  = rst;
    s_valid = sv;
    m_ready = mr;
    for (int i = 0; i < N_SRC; i++) s_data[i*DATA_W +: DATA_W] = srcWord(i, seqNo[i]);
    #1;
    if (modelKnown) checkAll();
    if (m_valid && m_ready) srcBeats[m_data[31:28]]++;
    modelStep(sv, mr, rst);
    @(posedge aclk);
  endtask

  task automatic clearBeats();
    for (int i = 0; i < 16; i++) srcBeats[i] = 0;
  endtask

  initial begin
    logic [N_SRC-1:0] rv;
    bit rr;
    areset  = 1'b0;
    s_valid = '0;
    s_data  = '0;
    m_ready = 1'b1;
    for (int i = 0; i < N_SRC; i++) seqNo[i] = 0;
    clearBeats();

    // Reset held two cycles with every source requesting.
    applyStimulus(4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    #1;
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_grant", 32'(grant_idx), 32'd3);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Lone requester src2: two full bursts separated by one idle cycle.
    clearBeats();
    for (int c = 0; c < 19; c++) applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("s2_src2_beats", 32'(srcBeats[2]), 32'd16);

    // All sources busy from reset: grants rotate 0,1,2,3,0 with full bursts.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    clearBeats();
    for (int c = 0; c < 46; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("s3_src0_beats", 32'(srcBeats[0]), 32'd16);
    checkOutput("s3_src1_beats", 32'(srcBeats[1]), 32'd8);
    checkOutput("s3_src2_beats", 32'(srcBeats[2]), 32'd8);
    checkOutput("s3_src3_beats", 32'(srcBeats[3]), 32'd8);

    // Backpressure in the middle of a burst.
    for (int c = 0; c < 2; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(4'b1111, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(4'b1111, 1'b1, 1'b0);

    // src1 stops after three beats while src3 is waiting.
    for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1, 1'b0);
    clearBeats();
    for (int c = 0; c < 4; c++) applyStimulus(4'b0010, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(4'b1000, 1'b1, 1'b0);
    #1;
    checkOutput("s5_grant", 32'(grant_idx), 32'd3);
    checkOutput("s5_src1_beats", 32'(srcBeats[1]), 32'd3);

    // Reset in the middle of a burst drops the held beat.
    for (int c = 0; c < 4; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    #1;
    checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
    for (int c = 0; c < 3; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
    #1;
    checkOutput("midrst_grant", 32'(grant_idx), 32'd0);

    // Randomized traffic and backpressure with occasional resets.
    for (int c = 0; c < 800; c++) begin
      rv = '0;
      for (int i = 0; i < N_SRC; i++) rv[i] = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 9) < 7);
      applyStimulus(rv, rr, ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
